// File: rtl/display_output.sv
// display_output: drives the EGO1 8-digit multiplexed 7-segment display and
// the 8 status LEDs from the hood's power, fan level, clock, countdown and
// gesture-window state. Two digits are lit per scan step (digit s and s+4).
// All board outputs come straight from registers, so the enables and both
// segment buses always change on the same edge.
module display_output #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power_on,
  input  logic [1:0] mode,
  input  logic [4:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic [6:0] countdown,
  input  logic       gesture_armed,
  output logic [7:0] seg_en,
  output logic [7:0] seg_a,
  output logic [7:0] seg_b,
  output logic [7:0] led
);

  localparam int SCAN_DIV  = CLK_FREQ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_FREQ / (2 * BLINK_HZ);
  localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [7:0] SEG_E     = 8'h9E;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Segment pattern {a,b,c,d,e,f,g,dp} for a decimal digit.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hFC;
      4'd1:    return 8'h60;
      4'd2:    return 8'hDA;
      4'd3:    return 8'hF2;
      4'd4:    return 8'h66;
      4'd5:    return 8'hB6;
      4'd6:    return 8'hBE;
      4'd7:    return 8'hE0;
      4'd8:    return 8'hFE;
      4'd9:    return 8'hF6;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Two-digit field {tens_code, ones_code}; an out-of-range field shows "EE".
  function automatic logic [15:0] field2(input logic [6:0] v, input logic bad);
    logic [6:0] t;
    logic [6:0] o;
    t = v / 7'd10;
    o = v % 7'd10;
    if (bad) return {SEG_E, SEG_E};
    return {seg7(t[3:0]), seg7(o[3:0])};
  endfunction

  logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
  logic [1:0]         scan_idx_q,  scan_idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q,     phase_d;
  logic               power_q;
  logic               armed_q;
  logic [7:0]         seg_en_q, seg_en_d;
  logic [7:0]         seg_a_q,  seg_a_d;
  logic [7:0]         seg_b_q,  seg_b_d;
  logic [7:0]         led_q,    led_d;

  logic power_rise;
  logic armed_rise;
  logic scan_tc;

  assign power_rise = power_on & ~power_q;
  assign armed_rise = gesture_armed & ~armed_q;
  assign scan_tc    = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));

  // Scan prescaler/index and blink phase; a power-on edge restarts the scan at
  // pair 0 even when it lands on a prescaler terminal count.
  always_comb begin
    scan_cnt_d  = scan_tc ? '0 : scan_cnt_q + SCAN_W'(1);
    scan_idx_d  = scan_idx_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (power_rise)   scan_idx_d = 2'd0;
    else if (scan_tc) scan_idx_d = scan_idx_q + 2'd1;
    if (!gesture_armed || armed_rise) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    end
    if (power_rise) phase_d = 1'b1;
  end

  // Next output register contents: the digit pair for the current scan step
  // and the LED pattern, all forced dark while power is off.
  always_comb begin
    logic [1:0]  s_view;
    logic [15:0] h_f, m_f, s_f;
    logic [6:0]  cd_v;
    logic [15:0] cd_f;
    logic [7:0]  dig1, dig0;

    s_view = power_rise ? 2'd0 : scan_idx_q;
    h_f    = field2({2'b00, hours}, hours >= 5'd24);
    m_f    = field2({1'b0, minutes}, minutes >= 6'd60);
    s_f    = field2({1'b0, seconds}, seconds >= 6'd60);
    cd_v   = (countdown >= 7'd99) ? 7'd99 : countdown;
    cd_f   = field2(cd_v, 1'b0);

    if (countdown != 7'd0) begin
      dig1 = phase_d ? cd_f[15:8] : SEG_BLANK;
      dig0 = phase_d ? cd_f[7:0]  : SEG_BLANK;
    end else begin
      dig1 = phase_d ? seg7({2'b00, mode}) : SEG_BLANK;
      dig0 = SEG_BLANK;
    end

    seg_en_d = 8'h11 << s_view;
    seg_a_d  = SEG_BLANK;
    seg_b_d  = SEG_BLANK;
    case (s_view)
      2'd3: begin seg_b_d = h_f[15:8];         seg_a_d = s_f[15:8]; end
      2'd2: begin seg_b_d = h_f[7:0] | 8'h01;  seg_a_d = s_f[7:0];  end
      2'd1: begin seg_b_d = m_f[15:8];         seg_a_d = dig1;      end
      default: begin seg_b_d = m_f[7:0] | 8'h01; seg_a_d = dig0;    end
    endcase

    led_d = {gesture_armed & phase_d, countdown != 7'd0, 2'b00,
             mode == 2'd3, mode == 2'd2, mode == 2'd1, power_on};

    if (!power_on) begin
      seg_en_d = 8'h00;
      seg_a_d  = 8'h00;
      seg_b_d  = 8'h00;
      led_d    = 8'h00;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_q  <= '0;
      scan_idx_q  <= 2'd0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      power_q     <= 1'b0;
      armed_q     <= 1'b0;
      seg_en_q    <= 8'h00;
      seg_a_q     <= 8'h00;
      seg_b_q     <= 8'h00;
      led_q       <= 8'h00;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      scan_idx_q  <= scan_idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      power_q     <= power_on;
      armed_q     <= gesture_armed;
      seg_en_q    <= seg_en_d;
      seg_a_q     <= seg_a_d;
      seg_b_q     <= seg_b_d;
      led_q       <= led_d;
    end
  end

  assign seg_en = seg_en_q;
  assign seg_a  = seg_a_q;
  assign seg_b  = seg_b_q;
  assign led    = led_q;

endmodule
